// File: rtl/dsa_nn_core.sv
`default_nettype none
// ============================================================================
// dsa_nn_core : nearest-neighbour downscale core. Walks the input BRAM with a
//               Q8.8 step and packs output pixels little-endian into 32-bit words.
// Option      : define DSA_CORE_ROW_PAD_EN to start every output row word-aligned.
// Revision    : 1.0
// ============================================================================
module dsa_nn_core #(
  parameter int PIX_W          = 8,
  parameter int IN_ADDR_WIDTH  = 18,
  parameter int OUT_ADDR_WIDTH = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [15:0]               img_w_i,
  input  logic [15:0]               img_h_i,
  input  logic [15:0]               scale_q8_8_i,
  input  logic [1:0]                mode_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [IN_ADDR_WIDTH-1:0]  in_addr_o,
  input  logic [31:0]               in_rdata_i,
  output logic [OUT_ADDR_WIDTH-1:0] out_addr_o,
  output logic [31:0]               out_wdata_o,
  output logic                      out_we_o,
  output logic                      pix_valid_o,
  output logic [15:0]               out_w_o,
  output logic [15:0]               out_h_o
);

  localparam int unsigned c_ppw     = 32 / PIX_W;
  localparam int          c_pkw     = (c_ppw > 1) ? $clog2(c_ppw) : 1;
  localparam logic [63:0] c_max_pix = 64'(c_ppw) << IN_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ROW   = 3'd2,
    S_RD    = 3'd3,
    S_CAP   = 3'd4,
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [15:0]               img_w_q, img_h_q, scale_q;
  logic [1:0]                mode_q;
  logic                      reject_q;
  logic [24:0]               x_acc_q, y_acc_q;
  logic [31:0]               row_base_q;
  logic [c_pkw-1:0]          lane_q, pk_q;
  logic [31:0]               pack_q;
  logic [OUT_ADDR_WIDTH-1:0] wa_q;
  logic [15:0]               ox_q, oy_q;

  logic                      busy_q, done_q, error_q, out_we_q;
  logic [IN_ADDR_WIDTH-1:0]  in_addr_q;
  logic [OUT_ADDR_WIDTH-1:0] out_addr_q;
  logic [31:0]               out_wdata_q;
  logic [15:0]               out_w_q, out_h_q;

  // Accumulators carry one guard bit so the step past the last column cannot wrap.
  logic [16:0]      w_sy, w_sx, w_sx_nxt;
  logic [24:0]      w_x_nxt;
  logic [31:0]      w_area, w_row_prod, w_idx_nxt;
  logic             w_reject, w_row_over, w_col_over;
  logic [PIX_W-1:0] w_pix;
  logic [31:0]      w_pack_ins;

  assign w_sy       = y_acc_q[24:8];
  assign w_sx       = x_acc_q[24:8];
  assign w_x_nxt    = x_acc_q + {9'b0, scale_q};
  assign w_sx_nxt   = w_x_nxt[24:8];
  assign w_area     = {16'b0, img_w_q} * {16'b0, img_h_q};
  assign w_row_prod = {16'b0, w_sy[15:0]} * {16'b0, img_w_q};
  assign w_idx_nxt  = row_base_q + {15'b0, w_sx_nxt};
  assign w_row_over = (w_sy >= {1'b0, img_h_q});
  assign w_col_over = (w_sx >= {1'b0, img_w_q});
  assign w_reject   = (img_w_q == 16'd0) || (img_h_q == 16'd0) || (scale_q < 16'h0100) ||
                      (mode_q != 2'b00) || ({32'b0, w_area} > c_max_pix);
  assign w_pix      = PIX_W'(in_rdata_i >> (lane_q * PIX_W));
  assign w_pack_ins = pack_q | (32'(w_pix) << (pk_q * PIX_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_CHECK;
      S_CHECK: state_d = w_reject ? S_DONE : S_ROW;
      S_ROW:   state_d = w_row_over ? S_FLUSH : S_RD;
      S_RD:    state_d = w_col_over ? S_ROW : S_CAP;
      S_CAP:   state_d = S_RD;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_w_q     <= '0;
      img_h_q     <= '0;
      scale_q     <= '0;
      mode_q      <= '0;
      reject_q    <= 1'b0;
      x_acc_q     <= '0;
      y_acc_q     <= '0;
      row_base_q  <= '0;
      lane_q      <= '0;
      pk_q        <= '0;
      pack_q      <= '0;
      wa_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      out_we_q    <= 1'b0;
      in_addr_q   <= '0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      out_w_q     <= '0;
      out_h_q     <= '0;
    end else begin
      out_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (done_q) busy_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            img_w_q <= img_w_i;
            img_h_q <= img_h_i;
            scale_q <= scale_q8_8_i;
            mode_q  <= mode_i;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            out_w_q <= '0;
            out_h_q <= '0;
          end
        end
        S_CHECK: begin
          reject_q <= w_reject;
          y_acc_q  <= '0;
          oy_q     <= '0;
          wa_q     <= '0;
          pk_q     <= '0;
          pack_q   <= '0;
        end
        S_ROW: begin
          // The first address of the row is issued here so RD already sees it on the bus.
          if (!w_row_over) begin
            row_base_q <= w_row_prod;
            x_acc_q    <= '0;
            ox_q       <= '0;
            in_addr_q  <= IN_ADDR_WIDTH'(w_row_prod / c_ppw);
            lane_q     <= c_pkw'(w_row_prod % c_ppw);
          end
        end
        S_RD: begin
          if (w_col_over) begin
            y_acc_q <= y_acc_q + {9'b0, scale_q};
            oy_q    <= oy_q + 16'd1;
            if (oy_q == 16'd0) out_w_q <= ox_q;
`ifdef DSA_CORE_ROW_PAD_EN
            if (pk_q != '0) begin
              out_we_q    <= 1'b1;
              out_addr_q  <= wa_q;
              out_wdata_q <= pack_q;
              wa_q        <= wa_q + OUT_ADDR_WIDTH'(1);
              pk_q        <= '0;
              pack_q      <= '0;
            end
`endif
          end
        end
        S_CAP: begin
          x_acc_q <= w_x_nxt;
          ox_q    <= ox_q + 16'd1;
          if (w_sx_nxt < {1'b0, img_w_q}) begin
            in_addr_q <= IN_ADDR_WIDTH'(w_idx_nxt / c_ppw);
            lane_q    <= c_pkw'(w_idx_nxt % c_ppw);
          end
          if (pk_q == c_pkw'(c_ppw - 1)) begin
            out_we_q    <= 1'b1;
            out_addr_q  <= wa_q;
            out_wdata_q <= w_pack_ins;
            wa_q        <= wa_q + OUT_ADDR_WIDTH'(1);
            pk_q        <= '0;
            pack_q      <= '0;
          end else begin
            pack_q <= w_pack_ins;
            pk_q   <= pk_q + c_pkw'(1);
          end
        end
        S_FLUSH: begin
          if (pk_q != '0) begin
            out_we_q    <= 1'b1;
            out_addr_q  <= wa_q;
            out_wdata_q <= pack_q;
            wa_q        <= wa_q + OUT_ADDR_WIDTH'(1);
            pk_q        <= '0;
            pack_q      <= '0;
          end
          out_h_q <= oy_q;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          error_q <= reject_q;
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign in_addr_o   = in_addr_q;
  assign out_addr_o  = out_addr_q;
  assign out_wdata_o = out_wdata_q;
  assign out_we_o    = out_we_q;
  assign pix_valid_o = (state_q == S_CAP);
  assign out_w_o     = out_w_q;
  assign out_h_o     = out_h_q;

endmodule
`default_nettype wire

// File: tb/tb_dsa_nn_core.sv
`default_nettype none
// tb_dsa_nn_core : self-checking bench; random images compared against a
// behavioural nearest-neighbour model computed with plain arithmetic.
module tb_dsa_nn_core;

  localparam int PIX_W     = 8;
  localparam int PPW       = 4;
  localparam int MEM_WORDS = 1024;
  localparam int JOB_LIMIT = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] img_w_i, img_h_i, scale_q8_8_i;
  logic [1:0]  mode_i;
  logic        busy_o, done_o, error_o, out_we_o, pix_valid_o;
  logic [17:0] in_addr_o, out_addr_o;
  logic [31:0] in_rdata_i, out_wdata_o;
  logic [15:0] out_w_o, out_h_o;

  logic [31:0] mem [0:MEM_WORDS-1];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          pv_cnt, done_cnt;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_words[$];
  int          exp_ow, exp_oh, exp_pix, exp_cycles;
  logic        busy_c1, busy_post, err_at_done, err_post;
  logic [15:0] ow_at_done, oh_at_done;

  always #5 clk = ~clk;

  dsa_nn_core #(.PIX_W(8), .IN_ADDR_WIDTH(18), .OUT_ADDR_WIDTH(18)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .img_w_i(img_w_i), .img_h_i(img_h_i),
    .scale_q8_8_i(scale_q8_8_i), .mode_i(mode_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .in_addr_o(in_addr_o), .in_rdata_i(in_rdata_i),
    .out_addr_o(out_addr_o), .out_wdata_o(out_wdata_o), .out_we_o(out_we_o),
    .pix_valid_o(pix_valid_o), .out_w_o(out_w_o), .out_h_o(out_h_o)
  );

  always @(posedge clk) in_rdata_i <= mem[in_addr_o[9:0]];

  always @(negedge clk) begin
    if (!rst) begin
      if (out_we_o) begin
        got_addr.push_back(32'(out_addr_o));
        got_data.push_back(out_wdata_o);
      end
      if (pix_valid_o) pv_cnt++;
      if (done_o) done_cnt++;
    end
  end

  task automatic fill_linear();
    for (int i = 0; i < MEM_WORDS; i++)
      mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endtask

  task automatic fill_random();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
  endtask

  // Reference: output pixel (ox,oy) samples source (floor(ox*s/256), floor(oy*s/256)).
  task automatic model(input int w, input int h, input int s);
    logic [31:0] cur, word, pix;
    int          slot, ow;
    longint      sy, sx, idx;
    exp_words.delete();
    cur = '0; slot = 0; exp_ow = 0; exp_oh = 0; exp_pix = 0;
    for (longint oy = 0; (oy * s) / 256 < h; oy++) begin
      sy = (oy * s) / 256;
      ow = 0;
      for (longint ox = 0; (ox * s) / 256 < w; ox++) begin
        sx   = (ox * s) / 256;
        idx  = sy * w + sx;
        word = mem[int'(idx / PPW)];
        pix  = (word >> (PIX_W * int'(idx % PPW))) & 32'hFF;
        cur  = cur | (pix << (PIX_W * slot));
        slot++;
        if (slot == PPW) begin
          exp_words.push_back(cur);
          cur = '0; slot = 0;
        end
        ow++;
      end
`ifdef DSA_CORE_ROW_PAD_EN
      if (slot != 0) begin
        exp_words.push_back(cur);
        cur = '0; slot = 0;
      end
`endif
      if (oy == 0) exp_ow = ow;
      exp_oh++;
      exp_pix += ow;
    end
    if (slot != 0) exp_words.push_back(cur);
    exp_cycles = 5 + exp_oh * (2 * exp_ow + 2);
  endtask

  // Runs one job; returns the start-to-done distance in cycles, or -1 on timeout.
  task automatic run_job(input int w, input int h, input int s, input int m,
                         input int extra_at, output int cycles);
    int n;
    got_addr.delete(); got_data.delete(); pv_cnt = 0; done_cnt = 0;
    @(negedge clk);
    img_w_i = 16'(w); img_h_i = 16'(h); scale_q8_8_i = 16'(s); mode_i = 2'(m);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 1;
    busy_c1 = busy_o;
    img_w_i = 16'($urandom); img_h_i = 16'($urandom);
    scale_q8_8_i = 16'($urandom); mode_i = 2'($urandom);
    cycles = -1;
    while (n <= JOB_LIMIT) begin
      if (done_o) begin
        cycles = n;
        break;
      end
      start_i = (n == extra_at);
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    err_at_done = error_o; ow_at_done = out_w_o; oh_at_done = out_h_o;
    @(negedge clk);
    busy_post = busy_o;
    err_post  = error_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; img_w_i = '0; img_h_i = '0; scale_q8_8_i = '0; mode_i = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_o, done_o, error_o, out_we_o, pix_valid_o, in_addr_o, out_addr_o,
         out_wdata_o, out_w_o, out_h_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b we=%b pv=%b wdata=%h, required all 0",
               busy_o, done_o, error_o, out_we_o, pix_valid_o, out_wdata_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_image_8x4();
    int cyc;
    fill_linear();
    run_job(8, 4, 16'h0200, 0, 0, cyc);
    n_cmp++;
    if (cyc !== 25) begin n_fail++; $display("FAIL 8x4_latency: got %0d required 25", cyc); end
    n_cmp++;
    if (got_data.size() !== 2) begin
      n_fail++; $display("FAIL 8x4_word_count: got %0d required 2", got_data.size());
    end else begin
      n_cmp++;
      if (got_data[0] !== 32'h06040200 || got_addr[0] !== 0) begin
        n_fail++; $display("FAIL 8x4_word0: got %h@%0d required 06040200@0", got_data[0], got_addr[0]);
      end
      n_cmp++;
      if (got_data[1] !== 32'h16141210 || got_addr[1] !== 1) begin
        n_fail++; $display("FAIL 8x4_word1: got %h@%0d required 16141210@1", got_data[1], got_addr[1]);
      end
    end
    n_cmp++;
    if (ow_at_done !== 16'd4 || oh_at_done !== 16'd2) begin
      n_fail++; $display("FAIL 8x4_dims: got %0dx%0d required 4x2", ow_at_done, oh_at_done);
    end
    n_cmp++;
    if (pv_cnt !== 8 || err_at_done !== 1'b0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL 8x4_pv_err_done: got pv=%0d err=%b done=%0d required 8/0/1",
                         pv_cnt, err_at_done, done_cnt);
    end
    n_cmp++;
    if (busy_c1 !== 1'b1 || busy_post !== 1'b0) begin
      n_fail++; $display("FAIL 8x4_busy: got c1=%b post=%b required 1/0", busy_c1, busy_post);
    end
  endtask

  task automatic test_fractional_6x1();
    int cyc;
    fill_linear();
    run_job(6, 1, 16'h0180, 0, 0, cyc);
    n_cmp++;
    if (got_data.size() !== 1 || got_data[0] !== 32'h04030100) begin
      n_fail++; $display("FAIL 6x1_word: got n=%0d w0=%h required 1 word 04030100",
                         got_data.size(), got_data.size() > 0 ? got_data[0] : 32'h0);
    end
    n_cmp++;
    if (ow_at_done !== 16'd4 || oh_at_done !== 16'd1 || cyc !== 15) begin
      n_fail++; $display("FAIL 6x1_dims_latency: got %0dx%0d in %0d required 4x1 in 15",
                         ow_at_done, oh_at_done, cyc);
    end
  endtask

  task automatic test_random_jobs();
    int w, h, s, cyc;
    for (int t = 0; t < 8; t++) begin
      fill_random();
      w = $urandom_range(1, 24);
      h = $urandom_range(1, 12);
      s = (t == 0) ? 16'h0100 : $urandom_range(16'h0100, 16'h0400);
      model(w, h, s);
      run_job(w, h, s, 0, 0, cyc);
      n_cmp++;
      if (cyc !== exp_cycles || pv_cnt !== exp_pix || err_at_done !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_timing: got cyc=%0d pv=%0d err=%b required %0d/%0d/0 (%0dx%0d s=%h)",
                           t, cyc, pv_cnt, err_at_done, exp_cycles, exp_pix, w, h, s);
      end
      n_cmp++;
      if (ow_at_done !== 16'(exp_ow) || oh_at_done !== 16'(exp_oh)) begin
        n_fail++; $display("FAIL rand%0d_dims: got %0dx%0d required %0dx%0d",
                           t, ow_at_done, oh_at_done, exp_ow, exp_oh);
      end
      n_cmp++;
      if (got_data.size() !== exp_words.size()) begin
        n_fail++; $display("FAIL rand%0d_word_count: got %0d required %0d",
                           t, got_data.size(), exp_words.size());
      end
      for (int i = 0; i < exp_words.size() && i < got_data.size(); i++) begin
        n_cmp++;
        if (got_data[i] !== exp_words[i] || got_addr[i] !== 32'(i)) begin
          n_fail++; $display("FAIL rand%0d_word%0d: got %h@%0d required %h@%0d",
                             t, i, got_data[i], got_addr[i], exp_words[i], i);
        end
      end
    end
  endtask

  task automatic test_reject();
    int cw[5] = '{8, 0, 8, 8, 1024};
    int ch[5] = '{4, 4, 0, 4, 1025};
    int cs[5] = '{16'h0200, 16'h0200, 16'h0200, 16'h00FF, 16'h0100};
    int cm[5] = '{1, 0, 0, 0, 0};
    int cyc;
    for (int k = 0; k < 5; k++) begin
      run_job(cw[k], ch[k], cs[k], cm[k], 0, cyc);
      n_cmp++;
      if (cyc !== 3 || err_at_done !== 1'b1 || got_data.size() !== 0 || err_post !== 1'b1) begin
        n_fail++; $display("FAIL reject%0d: got cyc=%0d err=%b writes=%0d held=%b required 3/1/0/1",
                           k, cyc, err_at_done, got_data.size(), err_post);
      end
    end
    fill_random();
    model(5, 3, 16'h0100);
    run_job(5, 3, 16'h0100, 0, 0, cyc);
    n_cmp++;
    if (err_at_done !== 1'b0 || cyc !== exp_cycles || got_data.size() !== exp_words.size()) begin
      n_fail++; $display("FAIL reject_recover: got err=%b cyc=%0d words=%0d required 0/%0d/%0d",
                         err_at_done, cyc, got_data.size(), exp_cycles, exp_words.size());
    end
  endtask

  task automatic test_reset_mid_job();
    int cyc;
    fill_random();
    @(negedge clk);
    img_w_i = 16'd16; img_h_i = 16'd4; scale_q8_8_i = 16'h0100; mode_i = 2'b00; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy_o, done_o, error_o, out_we_o, pix_valid_o, in_addr_o, out_addr_o,
         out_wdata_o, out_w_o, out_h_o} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got busy=%b pv=%b in_addr=%0d out_addr=%0d wdata=%h required all 0",
                         busy_o, pix_valid_o, in_addr_o, out_addr_o, out_wdata_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (done_cnt !== 0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_no_done: got done=%0d busy=%b required 0/0", done_cnt, busy_o);
    end
    model(7, 5, 16'h0140);
    run_job(7, 5, 16'h0140, 0, 0, cyc);
    n_cmp++;
    if (got_data.size() !== exp_words.size() || cyc !== exp_cycles) begin
      n_fail++; $display("FAIL midrst_rerun: got words=%0d cyc=%0d required %0d/%0d",
                         got_data.size(), cyc, exp_words.size(), exp_cycles);
    end
    for (int i = 0; i < exp_words.size() && i < got_data.size(); i++) begin
      n_cmp++;
      if (got_data[i] !== exp_words[i] || got_addr[i] !== 32'(i)) begin
        n_fail++; $display("FAIL midrst_word%0d: got %h@%0d required %h@%0d",
                           i, got_data[i], got_addr[i], exp_words[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int pulses[3] = '{2, 9, 30};
    fill_random();
    model(13, 6, 16'h01A0);
    for (int k = 0; k < 3; k++) begin
      run_job(13, 6, 16'h01A0, 0, pulses[k], cyc);
      n_cmp++;
      if (cyc !== exp_cycles || done_cnt !== 1 || got_data.size() !== exp_words.size()) begin
        n_fail++; $display("FAIL busy_start%0d: got cyc=%0d done=%0d words=%0d required %0d/1/%0d",
                           k, cyc, done_cnt, got_data.size(), exp_cycles, exp_words.size());
      end
      for (int i = 0; i < exp_words.size() && i < got_data.size(); i++) begin
        n_cmp++;
        if (got_data[i] !== exp_words[i] || got_addr[i] !== 32'(i)) begin
          n_fail++; $display("FAIL busy_start%0d_word%0d: got %h@%0d required %h@%0d",
                             k, i, got_data[i], got_addr[i], exp_words[i], i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_image_8x4();
    test_fractional_6x1();
    test_random_jobs();
    test_reject();
    test_reset_mid_job();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
